// File: rtl/glob_pkg.sv
// Shared types and token decode for the glob_matcher wildcard matching FSM.
package glob_pkg;

    localparam int unsigned KIND_LSB  = 8;
    localparam int unsigned KIND_W    = 2;
    localparam int unsigned MAX_SYM_W = 32;

    typedef enum logic [1:0] {
        LIT  = 2'b00,
        ANY1 = 2'b01,
        ANYN = 2'b10,
        RSVD = 2'b11
    } tok_kind_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CMP,
        TAIL_FETCH,
        TAIL_CHK,
        DONE_OK,
        DONE_FAIL,
        ERR
    } state_t;

    // A token consumes exactly one sequence symbol when this returns 1.
    function automatic logic is_hit(input tok_kind_t kind,
                                    input logic [MAX_SYM_W-1:0] tok_sym,
                                    input logic [MAX_SYM_W-1:0] sym);
        return (kind == ANY1) || ((kind == LIT) && (tok_sym == sym));
    endfunction

endpackage

// File: rtl/glob_matcher.sv
// Whole-sequence wildcard matcher (LIT / ? / *) with single-point greedy backtracking.
// Optional CMP-cycle counter output `steps` when GLOB_STEP_COUNT_EN is defined.
module glob_matcher
    import glob_pkg::*;
#(
    parameter int unsigned SYM_W     = KIND_LSB,
    parameter int unsigned SEQ_DEPTH = 64,
    parameter int unsigned PAT_DEPTH = 32,
    parameter int unsigned SA_W      = $clog2(SEQ_DEPTH + 1),
    parameter int unsigned PA_W      = $clog2(PAT_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [SA_W-1:0]    seq_len,
    input  logic [PA_W-1:0]    pat_len,
    output logic [SA_W-1:0]    seq_addr,
    input  logic [SYM_W-1:0]   seq_data,
    output logic [PA_W-1:0]    pat_addr,
    input  logic [SYM_W+1:0]   pat_data,
    output logic               busy,
    output logic               done,
    output logic               found,
`ifdef GLOB_STEP_COUNT_EN
    output logic [15:0]        steps,
`endif
    output logic               error
);

    localparam logic [SA_W-1:0] SEQ_MAX = SA_W'(SEQ_DEPTH);
    localparam logic [PA_W-1:0] PAT_MAX = PA_W'(PAT_DEPTH);

    state_t          state, state_n;
    logic [SA_W-1:0] s, s_n, mark, mark_n, seq_len_q, seq_len_n;
    logic [PA_W-1:0] p, p_n, star_p, star_p_n, pat_len_q, pat_len_n;
    logic            star_v, star_v_n;
    logic            busy_n, done_n, found_n, error_n;
    logic            idle_like;
    tok_kind_t       kind;
    logic            pat_left;

    assign kind      = tok_kind_t'(pat_data[SYM_W +: KIND_W]);
    assign pat_left  = (p < pat_len_q);
    assign idle_like = (state == IDLE) || (state == DONE_OK) ||
                       (state == DONE_FAIL) || (state == ERR);

    // Addresses come straight from the index registers; RAM data lands in the following state.
    assign seq_addr = s;
    assign pat_addr = p;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            p         <= '0;
            mark      <= '0;
            star_p    <= '0;
            star_v    <= 1'b0;
            seq_len_q <= '0;
            pat_len_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            p         <= p_n;
            mark      <= mark_n;
            star_p    <= star_p_n;
            star_v    <= star_v_n;
            seq_len_q <= seq_len_n;
            pat_len_q <= pat_len_n;
            busy      <= busy_n;
            done      <= done_n;
            found     <= found_n;
            error     <= error_n;
        end
    end

    always_comb begin
        state_n   = state;
        s_n       = s;
        p_n       = p;
        mark_n    = mark;
        star_p_n  = star_p;
        star_v_n  = star_v;
        seq_len_n = seq_len_q;
        pat_len_n = pat_len_q;

        case (state)
            IDLE, DONE_OK, DONE_FAIL, ERR: begin
                if (start) begin
                    seq_len_n = seq_len;
                    pat_len_n = pat_len;
                    s_n       = '0;
                    p_n       = '0;
                    star_v_n  = 1'b0;
                    state_n   = ((seq_len > SEQ_MAX) || (pat_len > PAT_MAX)) ? ERR : FETCH;
                end
            end
            FETCH: begin
                state_n = (s == seq_len_q) ? TAIL_FETCH : CMP;
            end
            CMP: begin
                if (pat_left && (kind == RSVD)) begin
                    state_n = ERR;
                end else if (pat_left && is_hit(kind, MAX_SYM_W'(pat_data[SYM_W-1:0]),
                                                MAX_SYM_W'(seq_data))) begin
                    s_n     = s + SA_W'(1);
                    p_n     = p + PA_W'(1);
                    state_n = FETCH;
                end else if (pat_left && (kind == ANYN)) begin
                    star_p_n = p;
                    mark_n   = s;
                    star_v_n = 1'b1;
                    p_n      = p + PA_W'(1);
                    state_n  = FETCH;
                end else if (star_v) begin
                    // Let the star swallow one more symbol and retry the rest of the pattern.
                    p_n     = star_p + PA_W'(1);
                    mark_n  = mark + SA_W'(1);
                    s_n     = mark + SA_W'(1);
                    state_n = FETCH;
                end else begin
                    state_n = DONE_FAIL;
                end
            end
            TAIL_FETCH: begin
                state_n = (p == pat_len_q) ? DONE_OK : TAIL_CHK;
            end
            TAIL_CHK: begin
                if (kind == ANYN) begin
                    p_n     = p + PA_W'(1);
                    state_n = TAIL_FETCH;
                end else if (kind == RSVD) begin
                    state_n = ERR;
                end else begin
                    state_n = DONE_FAIL;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n  = (state_n == FETCH) || (state_n == CMP) ||
                  (state_n == TAIL_FETCH) || (state_n == TAIL_CHK);
        done_n  = (state_n == DONE_OK) || (state_n == DONE_FAIL) || (state_n == ERR);
        found_n = (state_n == DONE_OK);
        error_n = (state_n == ERR);
    end

`ifdef GLOB_STEP_COUNT_EN
    // Saturating count of CMP cycles for the current job.
    always_ff @(posedge clock) begin
        if (reset) begin
            steps <= '0;
        end else if (idle_like && start) begin
            steps <= '0;
        end else if ((state == CMP) && (steps != 16'hFFFF)) begin
            steps <= steps + 16'd1;
        end
    end
`else
    logic unused_idle_like;
    assign unused_idle_like = idle_like;
`endif

endmodule
